instruction_encoder: RTL and testbench

Streaming encoder that turns decoded uCISC instruction field bundles back into 16-bit instruction words and writes them sequentially into program memory. It is the write-side counterpart of the instruction decode path, used by the boot/program loader and by self-test logic to build code images from field-level descriptions. Each accepted bundle is checked for encodability, packed, and issued on a stallable memory write port with an auto-incrementing address. Encoding or protocol violations halt the stream in a sticky error state.

---
 rtl/instruction_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder
// Streaming uCISC instruction encoder. Accepts decoded field bundles, checks
// that each one is encodable, packs it into a 16-bit instruction word and
// issues it on a stallable program-memory write port with an auto-incrementing
// address. A bundle that cannot be encoded halts the stream in a sticky error
// state that only reset leaves.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start, base_addr     in IDLE: load first write address, clear count, run
//   in_valid/in_ready    bundle handshake
//   in_class ..in_last   bundle fields (class 0 copy, 1 alu, 2 page, 3 illegal)
//   mem_we/mem_ready     write handshake, mem_addr/mem_data held while stalled
//   busy, done, error    status (done pulses once after the final write)
//   error_code           1 illegal class, 2 immediate range, 3 alu_code[4]
//   count                words written since start
//   checksum             only with UCISC_ENCODER_CHECKSUM_EN: 16-bit running
//                        sum of written words, cleared on start
module instruction_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_source,
    input  logic [2:0]        in_destination,
    input  logic [2:0]        in_effect,
    input  logic [6:0]        in_immediate,
    input  logic [4:0]        in_alu_code,
    input  logic              in_increment,
    input  logic              in_page_dir,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W-1:0] count
`ifdef UCISC_ENCODER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [1:0] CLASS_COPY = 2'd0;
    localparam logic [1:0] CLASS_ALU  = 2'd1;
    localparam logic [1:0] CLASS_PAGE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Returns 0 for an encodable bundle, otherwise the error code.
    function automatic logic [1:0] check_bundle(
        input logic [1:0] cls,
        input logic [6:0] imm,
        input logic [4:0] alu
    );
        logic [1:0] code;
        code = 2'd0;
        case (cls)
            CLASS_COPY: if (imm[6] != imm[5]) code = 2'd2; else code = 2'd0;
            CLASS_ALU:  if (alu[4]) code = 2'd3; else code = 2'd0;
            CLASS_PAGE: code = 2'd0;
            default:    code = 2'd1;
        endcase
        return code;
    endfunction

    // Packs the fields of one bundle into its 16-bit instruction word.
    function automatic logic [15:0] encode_word(
        input logic [1:0] cls,
        input logic [2:0] src,
        input logic [2:0] dst,
        input logic [2:0] eff,
        input logic [5:0] imm,
        input logic [3:0] alu,
        input logic       inc,
        input logic       dir
    );
        logic [15:0] word;
        word = 16'h0000;
        case (cls)
            CLASS_COPY: word = {1'b0, eff, dst, src, imm};
            CLASS_ALU:  word = {2'b10, eff, dst, src, inc, alu};
            CLASS_PAGE: word = {3'b110, dir, src, eff, 6'b000000};
            default:    word = 16'h0000;
        endcase
        return word;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              last_pending_r;
    logic              mem_we_r;
    logic              done_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] count_r;
    logic [15:0]       mem_data_r;
    logic [1:0]        error_code_r;
    logic [1:0]        check_s;
    logic [15:0]       word_s;
    logic              ready_s;
    logic              accept_s;
    logic              write_s;

    // Handshake qualification, bundle check/encode and next-state selection.
    always_comb begin
        ready_s      = 1'b0;
        write_s      = 1'b0;
        accept_s     = 1'b0;
        state_next_s = state_r;
        // The single output register may reload in the cycle its word leaves.
        ready_s  = (state_r == ST_RUN) && !last_pending_r && (!mem_we_r || mem_ready);
        write_s  = mem_we_r && mem_ready;
        accept_s = in_valid && ready_s;
        check_s  = check_bundle(in_class, in_immediate, in_alu_code);
        word_s   = encode_word(in_class, in_source, in_destination, in_effect,
                               in_immediate[5:0], in_alu_code[3:0],
                               in_increment, in_page_dir);
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                // A failed check wins even over an in_last bundle.
                if (accept_s && (check_s != 2'd0))   state_next_s = ST_ERROR;
                else if (write_s && last_pending_r)  state_next_s = ST_IDLE;
                else                                 state_next_s = ST_RUN;
            end
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Output register, address/count tracking and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_pending_r <= 1'b0;
            mem_we_r       <= 1'b0;
            done_r         <= 1'b0;
            next_addr_r    <= {ADDR_W{1'b0}};
            mem_addr_r     <= {ADDR_W{1'b0}};
            count_r        <= {ADDR_W{1'b0}};
            mem_data_r     <= 16'h0000;
            error_code_r   <= 2'd0;
        end else begin
            done_r <= 1'b0;
            if ((state_r == ST_IDLE) && start) begin
                next_addr_r    <= base_addr;
                count_r        <= {ADDR_W{1'b0}};
                last_pending_r <= 1'b0;
            end
            // A held word always completes, even after an error is flagged.
            if (write_s) begin
                mem_we_r <= 1'b0;
                count_r  <= count_r + ADDR_ONE;
                if (last_pending_r) begin
                    last_pending_r <= 1'b0;
                    done_r         <= 1'b1;
                end
            end
            // Accept overrides the clear above when the register reloads.
            if (accept_s) begin
                if (check_s != 2'd0) begin
                    error_code_r <= check_s;
                end else begin
                    mem_we_r       <= 1'b1;
                    mem_addr_r     <= next_addr_r;
                    mem_data_r     <= word_s;
                    next_addr_r    <= next_addr_r + ADDR_ONE;
                    last_pending_r <= in_last;
                end
            end
        end
    end

`ifdef UCISC_ENCODER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running 16-bit sum of the words the memory has taken; restarts per image.
    always_ff @(posedge clock) begin
        if (reset)                            checksum_r <= 16'h0000;
        else if ((state_r == ST_IDLE) && start) checksum_r <= 16'h0000;
        else if (write_s)                     checksum_r <= checksum_r + mem_data_r;
        else                                  checksum_r <= checksum_r;
    end

    assign checksum = checksum_r;
`else
    // Checksum not built: no extra port or state.
`endif

    assign in_ready   = ready_s;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_data   = mem_data_r;
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign error      = (state_r == ST_ERROR);
    assign error_code = error_code_r;
    assign count      = count_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// Testbench for instruction_encoder: randomized bundle streams scored against
// a field-arithmetic reference model, plus directed encode/error/reset steps.
// Honours UCISC_ENCODER_CHECKSUM_EN when the design is built with it.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_class;
    logic [2:0]  in_source;
    logic [2:0]  in_destination;
    logic [2:0]  in_effect;
    logic [6:0]  in_immediate;
    logic [4:0]  in_alu_code;
    logic        in_increment;
    logic        in_page_dir;
    logic        in_last;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [15:0] count;
`ifdef UCISC_ENCODER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    instruction_encoder #(.ADDR_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
        .in_source(in_source), .in_destination(in_destination),
        .in_effect(in_effect), .in_immediate(in_immediate),
        .in_alu_code(in_alu_code), .in_increment(in_increment),
        .in_page_dir(in_page_dir), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .count(count)
`ifdef UCISC_ENCODER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   exp_addr_q[$];
    int   exp_data_q[$];
    int   exp_addr;
    int   stream_n;
    int   written;
    int   model_sum;
    logic expect_done;
    logic done_seen;
    logic acc_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference word from the documented field layouts, by plain arithmetic.
    function automatic int ref_word(int cls, int src, int dst, int eff, int imm,
                                    int alu, int inc, int dir);
        int w;
        w = 0;
        if (cls == 0)      w = eff * 4096 + dst * 512 + src * 64 + (((imm % 64) + 64) % 64);
        else if (cls == 1) w = 32768 + eff * 2048 + dst * 256 + src * 32 + inc * 16 + (alu % 16);
        else               w = 49152 + dir * 4096 + src * 512 + eff * 64;
        return w;
    endfunction

    task automatic drive_bundle(input logic [1:0] cls, input logic [2:0] src,
                                input logic [2:0] dst, input logic [2:0] eff,
                                input logic [6:0] imm, input logic [4:0] alu,
                                input logic inc, input logic dir, input logic last);
        in_valid = 1'b1; in_class = cls; in_source = src; in_destination = dst;
        in_effect = eff; in_immediate = imm; in_alu_code = alu;
        in_increment = inc; in_page_dir = dir; in_last = last;
    endtask

    // Random encodable bundle; fields unused by the class are random too.
    task automatic gen_bundle(input int cls_mode, input logic last);
        int imm_i;
        imm_i = $urandom_range(0, 63) - 32;
        drive_bundle((cls_mode == 0) ? 2'd0 : 2'($urandom_range(0, 2)),
                     3'($urandom), 3'($urandom), 3'($urandom), 7'(imm_i),
                     5'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), last);
    endtask

    task automatic set_ready(input int rmode);
        if (rmode == 0)      mem_ready = 1'b1;
        else if (rmode == 1) mem_ready = (cyc % 2) == 1;
        else                 mem_ready = 1'($urandom);
        cyc++;
    endtask

    // Per-cycle scoreboard step, called with inputs settled before the edge.
    task automatic observe();
        chk("done", 32'(done), 32'(expect_done));
        if (expect_done) begin
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("count_at_done", 32'(count), 32'(written));
`ifdef UCISC_ENCODER_CHECKSUM_EN
            chk("checksum_at_done", 32'(checksum), 32'(model_sum));
`endif
            done_seen   = 1'b1;
            expect_done = 1'b0;
        end
        chk("mem_we", 32'(mem_we), 32'(exp_addr_q.size() != 0));
        if (mem_we && exp_addr_q.size() != 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q[0]));
            chk("mem_data", 32'(mem_data), 32'(exp_data_q[0]));
            if (!mem_ready) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end else begin
                model_sum = (model_sum + exp_data_q[0]) % 65536;
                void'(exp_addr_q.pop_front());
                void'(exp_data_q.pop_front());
                written++;
                if (written == stream_n) expect_done = 1'b1;
            end
        end
        if (in_valid && in_ready) begin
            acc_flag = 1'b1;
            exp_addr_q.push_back(exp_addr);
            exp_data_q.push_back(ref_word(int'(in_class), int'(in_source),
                int'(in_destination), int'(in_effect), int'($signed(in_immediate)),
                int'(in_alu_code), int'(in_increment), int'(in_page_dir)));
            exp_addr = (exp_addr + 1) % 65536;
        end
    endtask

    task automatic run_stream(input int n, input logic [15:0] base, input int rmode,
                              input int cls_mode);
        exp_addr_q.delete(); exp_data_q.delete();
        stream_n = n; written = 0; model_sum = 0; exp_addr = int'(base);
        expect_done = 1'b0; done_seen = 1'b0;
        in_valid = 1'b0; mem_ready = 1'b1; start = 1'b1; base_addr = base;
        @(negedge clock);
        start = 1'b0; base_addr = 16'($urandom);
        #1;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("in_ready_after_start", 32'(in_ready), 32'd1);
        chk("count_after_start", 32'(count), 32'd0);
        for (int i = 0; i < n; i++) begin
            gen_bundle(cls_mode, i == n - 1);
            acc_flag = 1'b0;
            for (int t = 0; t < 40 && !acc_flag; t++) begin
                set_ready(rmode);
                // Random start pulses while running must be ignored.
                start = (rmode == 2) ? 1'($urandom) : 1'b0;
                #1; observe();
                @(negedge clock);
            end
            chk("accept_in_time", 32'(acc_flag), 32'd1);
        end
        in_valid = 1'b0; start = 1'b0;
        for (int t = 0; t < 80 && !done_seen; t++) begin
            set_ready(rmode);
            #1; observe();
            @(negedge clock);
        end
        chk("done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_error_code"}, 32'(error_code), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
`ifdef UCISC_ENCODER_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0; start = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = 16'h0000; mem_ready = 1'b1;
        drive_bundle(2'd0, 3'd0, 3'd0, 3'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1; check_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        // Basic image: three copies from 0x0100, memory always ready.
        run_stream(3, 16'h0100, 0, 0);

        // Copy encode, then an out-of-range immediate behind it.
        start = 1'b1; base_addr = 16'h0200; mem_ready = 1'b1;
        @(negedge clock); start = 1'b0;
        drive_bundle(2'd0, 3'd1, 3'd2, 3'd4, 7'h7F, 5'd0, 1'b0, 1'b0, 1'b0);
        #1; chk("copy_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        drive_bundle(2'd0, 3'd1, 3'd2, 3'd4, 7'h20, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("copy_we", 32'(mem_we), 32'd1);
        chk("copy_addr", 32'(mem_addr), 32'h0200);
        chk("copy_data", 32'(mem_data), 32'h447F);
        @(negedge clock); in_valid = 1'b0;
        #1;
        chk("imm_error", 32'(error), 32'd1);
        chk("imm_error_code", 32'(error_code), 32'd2);
        chk("imm_no_write", 32'(mem_we), 32'd0);
        chk("imm_count", 32'(count), 32'd1);
        // Error is sticky: start and bundles are ignored.
        start = 1'b1;
        drive_bundle(2'd0, 3'd1, 3'd1, 3'd1, 7'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock); start = 1'b0;
        #1;
        chk("sticky_error", 32'(error), 32'd1);
        chk("sticky_in_ready", 32'(in_ready), 32'd0);
        chk("sticky_no_write", 32'(mem_we), 32'd0);
        pulse_reset();

        // ALU encode, then alu_code with bit 4 set.
        start = 1'b1; base_addr = 16'h0300;
        @(negedge clock); start = 1'b0;
        drive_bundle(2'd1, 3'd2, 3'd1, 3'd0, 7'd0, 5'h0A, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        drive_bundle(2'd1, 3'd2, 3'd1, 3'd0, 7'd0, 5'h10, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_addr", 32'(mem_addr), 32'h0300);
        chk("alu_data", 32'(mem_data), 32'h815A);
        @(negedge clock); in_valid = 1'b0;
        #1;
        chk("alu_error", 32'(error), 32'd1);
        chk("alu_error_code", 32'(error_code), 32'd3);
        pulse_reset();

        // Illegal class flagged in_last: error wins, no done.
        start = 1'b1; base_addr = 16'h0400;
        @(negedge clock); start = 1'b0;
        drive_bundle(2'd3, 3'd0, 3'd0, 3'd0, 7'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clock); in_valid = 1'b0;
        #1;
        chk("class_error_code", 32'(error_code), 32'd1);
        chk("class_no_done", 32'(done), 32'd0);
        chk("class_busy", 32'(busy), 32'd1);
        @(negedge clock);
        #1; chk("class_no_done_later", 32'(done), 32'd0);
        pulse_reset();

        // Toggling backpressure, mixed classes.
        run_stream(8, 16'($urandom), 1, 3);
        // Address wrap.
        run_stream(2, 16'hFFFF, 0, 3);
        // Random backpressure with ignored start pulses.
        run_stream(20, 16'($urandom), 2, 3);

        // Reset while a write is held.
        start = 1'b1; base_addr = 16'h1234;
        @(negedge clock); start = 1'b0;
        gen_bundle(0, 1'b0); mem_ready = 1'b0;
        @(negedge clock); in_valid = 1'b0;
        #1; chk("mid_we_held", 32'(mem_we), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        #1; check_reset_values("mid_reset");
        reset = 1'b0;
        @(negedge clock);
        run_stream(5, 16'($urandom), 2, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
